// File: rtl/shift_add_multiplier.sv
// rtl/shift_add_multiplier.sv - sequential unsigned shift-and-add multiplier
// Built from half_adder cells chained into a WIDTH-bit ripple-carry adder.

module half_adder (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i;
  assign c_o = a_i & b_i;
endmodule

module full_adder_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  logic s1, c1, c2;

  half_adder u_ha0 (.a_i(a_i), .b_i(b_i), .s_o(s1),  .c_o(c1));
  half_adder u_ha1 (.a_i(s1),  .b_i(c_i), .s_o(s_o), .c_o(c2));

  assign c_o = c1 | c2;
endmodule

module ripple_adder #(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W:0]   sum_o
);
  logic [W:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < W; i++) begin : g_bit
    full_adder_cell u_fa (
      .a_i(a_i[i]),
      .b_i(b_i[i]),
      .c_i(carry[i]),
      .s_o(sum_o[i]),
      .c_o(carry[i+1])
    );
  end

  assign sum_o[W] = carry[W];
endmodule

module shift_add_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] P
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic {IDLE, CALC} state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH:0]     acc_hi_q;
  logic [WIDTH-1:0]   acc_lo_q;
  logic [CW-1:0]      cnt_q;
  logic               busy_q;
  logic               done_q;
  logic [2*WIDTH-1:0] p_q;

  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH:0]   shift_d;
  logic               unused_top;

  assign addend = acc_lo_q[0] ? mcand_q : '0;

  ripple_adder #(.W(WIDTH)) u_add (
    .a_i(acc_hi_q[WIDTH-1:0]),
    .b_i(addend),
    .sum_o(sum)
  );

  // {0, sum, acc_lo} shifted right by one; acc_lo[0] has just been consumed.
  assign shift_d    = {1'b0, sum, acc_lo_q[WIDTH-1:1]};
  assign unused_top = acc_hi_q[WIDTH] ^ shift_d[2*WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      p_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            mcand_q  <= A;
            acc_lo_q <= B;
            acc_hi_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= CALC;
          end
        end
        CALC: begin
          acc_hi_q <= shift_d[2*WIDTH:WIDTH];
          acc_lo_q <= shift_d[WIDTH-1:0];
          cnt_q    <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            p_q     <= shift_d[2*WIDTH-1:0];
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign P    = p_q;
endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb/tb_shift_add_multiplier.sv - randomized and directed checks against a product model
// Two instances (WIDTH=8 and WIDTH=4) share one clock.

module tb_shift_add_multiplier;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst8 = 1'b1, start8 = 1'b0, busy8, done8;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [15:0] p8;
  logic        rst4 = 1'b1, start4 = 1'b0, busy4, done4;
  logic [3:0]  a4 = '0, b4 = '0;
  logic [7:0]  p4;

  shift_add_multiplier #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst8), .start(start8), .A(a8), .B(b8),
    .busy(busy8), .done(done8), .P(p8)
  );
  shift_add_multiplier #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst4), .start(start4), .A(a4), .B(b4),
    .busy(busy4), .done(done4), .P(p4)
  );

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Model: an accepted op finishes WIDTH edges later with the plain product.
  logic        mb8 = 1'b0, md8 = 1'b0;
  logic [15:0] mp8 = '0, mprod8 = '0;
  int          mrem8 = 0;
  always @(posedge clk) begin
    if (rst8) begin
      mb8 <= 1'b0; md8 <= 1'b0; mp8 <= '0; mrem8 <= 0;
    end else begin
      md8 <= 1'b0;
      if (!mb8) begin
        if (start8) begin
          mb8 <= 1'b1; mrem8 <= 8; mprod8 <= 16'(a8) * 16'(b8);
        end
      end else if (mrem8 == 1) begin
        mb8 <= 1'b0; md8 <= 1'b1; mp8 <= mprod8;
      end else begin
        mrem8 <= mrem8 - 1;
      end
    end
  end

  logic       mb4 = 1'b0, md4 = 1'b0;
  logic [7:0] mp4 = '0, mprod4 = '0;
  int         mrem4 = 0;
  always @(posedge clk) begin
    if (rst4) begin
      mb4 <= 1'b0; md4 <= 1'b0; mp4 <= '0; mrem4 <= 0;
    end else begin
      md4 <= 1'b0;
      if (!mb4) begin
        if (start4) begin
          mb4 <= 1'b1; mrem4 <= 4; mprod4 <= 8'(a4) * 8'(b4);
        end
      end else if (mrem4 == 1) begin
        mb4 <= 1'b0; md4 <= 1'b1; mp4 <= mprod4;
      end else begin
        mrem4 <= mrem4 - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy8", 32'(busy8), 32'(mb8));
      chk("done8", 32'(done8), 32'(md8));
      chk("P8",    32'(p8),    32'(mp8));
      chk("busy4", 32'(busy4), 32'(mb4));
      chk("done4", 32'(done4), 32'(md4));
      chk("P4",    32'(p4),    32'(mp4));
    end
  end

  task automatic wait_done8(output int lat);
    lat = 99;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done8) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp, input string nm);
    int lat;
    a8 = a; b8 = b; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom);
    wait_done8(lat);
    chk({nm, "_lat"}, 32'(lat), 32'd8);
    chk({nm, "_P"}, 32'(p8), 32'(exp));
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp);
    int lat;
    a4 = a; b4 = b; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    lat = 99;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (done4) begin
        lat = i;
        break;
      end
    end
    chk("w4_lat", 32'(lat), 32'd4);
    chk("w4_P", 32'(p4), 32'(exp));
  endtask

  initial begin
    int lat;
    int seen;
    repeat (2) @(negedge clk);
    rst8 = 1'b0; rst4 = 1'b0;
    chk("rst_busy8", 32'(busy8), 32'd0);
    chk("rst_done8", 32'(done8), 32'd0);
    chk("rst_P8",    32'(p8),    32'd0);
    chk_en = 1'b1;

    op8(8'h0F, 8'h0F, 16'h00E1, "0f_0f");
    chk("busy_with_done", 32'(busy8), 32'd0);
    op8(8'hFF, 8'hFF, 16'hFE01, "ff_ff");
    op8(8'h00, 8'hAB, 16'h0000, "00_ab");
    op8(8'h80, 8'h02, 16'h0100, "80_02");

    // start held high, operands changed mid-operation
    a8 = 8'd3; b8 = 8'd5; start8 = 1'b1;
    @(negedge clk);
    a8 = 8'd7; b8 = 8'd9;
    wait_done8(lat);
    chk("held1_lat", 32'(lat), 32'd8);
    chk("held1_P", 32'(p8), 32'd15);
    wait_done8(lat);
    start8 = 1'b0;
    chk("held_spacing", 32'(lat), 32'd9);
    chk("held2_P", 32'(p8), 32'd63);
    repeat (2) @(negedge clk);

    // start pulse while busy is ignored
    a8 = 8'h12; b8 = 8'h34; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    lat = 99;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 2) begin
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
      end else begin
        start8 = 1'b0;
      end
      if (done8) begin
        lat = i;
        break;
      end
    end
    chk("ign_lat", 32'(lat), 32'd8);
    chk("ign_P", 32'(p8), 32'h03A8);

    // reset mid-operation
    a8 = 8'h55; b8 = 8'h55; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    rst8 = 1'b0; start8 = 1'b0;
    chk("abort_busy", 32'(busy8), 32'd0);
    chk("abort_done", 32'(done8), 32'd0);
    chk("abort_P", 32'(p8), 32'd0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8) seen++;
    end
    chk("abort_no_done", 32'(seen), 32'd0);
    op8(8'h55, 8'h55, 16'h1C39, "55_55");

    // random traffic, checked cycle by cycle against the model
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      start8 = ($urandom_range(0, 3) == 0);
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      rst8 = ($urandom_range(0, 99) == 0);
    end
    @(negedge clk);
    rst8 = 1'b0; start8 = 1'b0;
    repeat (12) @(negedge clk);

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        op4(4'(a), 4'(b), 8'(a * b));

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/shift_add_multiplier.md
Name: shift_add_multiplier

Overview:
- Sequential unsigned shift-and-add multiplier.
- Consumes the team's 1-bit adder cells: a WIDTH-bit ripple-carry adder, with each bit built as two half_adder instances plus an OR for carry-out.
- Accepts one operand pair per start pulse, iterates one multiplier bit per clock, and returns a 2*WIDTH-bit product with a one-cycle done pulse.
- Feeds the multiplier-lab top level and its display/readout logic.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..16.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request; sampled only in IDLE.
- A  input  WIDTH  multiplicand, unsigned; sampled on the accepting edge.
- B  input  WIDTH  multiplier, unsigned; sampled on the accepting edge.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; P is valid and final in this cycle.
- P  output  2*WIDTH  registered product; holds until the next done.

Behaviour:
- Clocking and reset:
  - One clock domain; all state changes on the rising clk edge.
  - rst sampled high: state=IDLE, busy=0, done=0, P=0, internal accumulator/counter=0.
- Registers:
  - mcand (WIDTH).
  - acc_hi (WIDTH+1; the extra bit is the carry).
  - acc_lo (WIDTH; initially holds the multiplier).
  - cnt (clog2(WIDTH)+1).
- States: IDLE, CALC. No separate DONE state; done is a registered flag.
- IDLE:
  - start=1 at edge e0: mcand<=A, acc_lo<=B, acc_hi<=0, cnt<=0, busy<=1, state->CALC.
  - start=0: remain in IDLE.
- CALC, each edge:
  - sum = acc_hi[WIDTH-1:0] + (acc_lo[0] ? mcand : 0), computed by the ripple adder; sum is WIDTH+1 bits including carry-out.
  - {acc_hi, acc_lo} <= {1'b0, sum, acc_lo} >> 1, i.e. a logical right shift of the concatenation.
  - cnt <= cnt+1.
- Completion:
  - On the edge where cnt==WIDTH-1 (edge eWIDTH), the final shifted value {acc_hi[WIDTH-1:0], acc_lo} is written to P.
  - Same edge: done<=1, busy<=0, state->IDLE.
- Latency: done is high in the cycle following edge e0+WIDTH, i.e. exactly WIDTH cycles after start is accepted.
- done:
  - Deasserts on the next edge unconditionally.
  - Never high for two consecutive cycles.
- start handling:
  - start while busy=1: ignored, with no effect on operands or timing.
  - start during the done cycle: accepted, since state is already IDLE. Minimum accept-to-accept spacing is WIDTH+1 cycles.
  - start held high continuously: a new operation is accepted every WIDTH+1 cycles.
- Operand sampling: A and B are sampled only at the accepting edge; later changes have no effect.
- P:
  - Unchanged at accept time and during CALC; it shows the previous result until the new done.
  - No overflow is possible, since 2*WIDTH bits hold the full unsigned product.
- Reset mid-operation: aborts immediately. busy=0, done=0, P=0; no done pulse for the aborted operation. The next start behaves normally.
- rst and start high on the same edge: rst wins and start is dropped.
- X/undriven A or B are not sampled while busy.

Test Plan:
- WIDTH=8, A=0x0F, B=0x0F, start pulse at edge 0 -> busy=1 for 8 cycles; done=1 for exactly 1 cycle after edge 8; P=0x00E1; busy=0 alongside done.
- A=0xFF, B=0xFF -> P=0xFE01 (carry path fully exercised). Then A=0x00, B=0xAB -> P=0x0000. Then A=0x80, B=0x02 -> P=0x0100.
- start held high with A=3, B=5, then A=7 and B=9 changed mid-operation -> first done gives P=15. Next op accepted in the done cycle yields P=63. done pulses exactly 9 cycles apart.
- Op A=0x12, B=0x34 in flight; at cycle 3 pulse start with A=0xFF, B=0xFF -> ignored; P=0x03A8 at the normal done time.
- rst asserted at cycle 4 of A=0x55, B=0x55 -> next cycle busy=0, done=0, P=0, and no done pulse for that op. New start A=0x55, B=0x55 -> P=0x1C39 after 8 cycles.
- WIDTH=4 build: exhaustive 256 operand pairs, compared against A*B -> every P matches; every done occurs 4 cycles after its accepting edge.
